// File: rtl/full_adder_1bit_reg_if.sv
// Operand/result bundle for the registered 1-bit full adder.
// Pure wiring, no latency; no backpressure (fixed-rate, one result per clock).
interface full_adder_1bit_reg_if;
    logic cin;
    logic a;
    logic b;
    logic sum;
    logic cout;

    modport master (
        output cin,
        output a,
        output b,
        input  sum,
        input  cout
    );

    modport slave (
        input  cin,
        input  a,
        input  b,
        output sum,
        output cout
    );
endinterface

// File: rtl/full_adder_1bit_reg.sv
// Gate-level 1-bit full adder with registered sum/carry and async active-high clear.
// Latency 1 rising clk edge; no backpressure, a new result is captured every edge.
module full_adder_1bit_reg (
    input  logic cin,
    input  logic a,
    input  logic b,
    input  logic clk,
    output logic sum,
    output logic cout,
    input  logic rst
);
    // Flat scalar ports keep positional compatibility with existing adder netlists.
    full_adder_1bit_reg_if fa_bus ();

    assign fa_bus.cin = cin;
    assign fa_bus.a   = a;
    assign fa_bus.b   = b;
    assign sum        = fa_bus.sum;
    assign cout       = fa_bus.cout;

    full_adder_1bit_reg_core u_core (
        .clk (clk),
        .rst (rst),
        .bus (fa_bus.slave)
    );
endmodule

module full_adder_1bit_reg_core (
    input  logic                        clk,
    input  logic                        rst,
    full_adder_1bit_reg_if.slave        bus
);
    logic a_w;
    logic b_w;
    logic cin_w;
    logic p;
    logic g1;
    logic g2;
    logic sum_d;
    logic cout_d;
    logic sum_q;
    logic cout_q;

    assign a_w   = bus.a;
    assign b_w   = bus.b;
    assign cin_w = bus.cin;

    // One primitive per gate so each is a separate SDF annotation point.
    xor u_ha1_x (p,      a_w, b_w);
    and u_ha1_a (g1,     a_w, b_w);
    xor u_ha2_x (sum_d,  p,   cin_w);
    and u_ha2_a (g2,     p,   cin_w);
    or  u_co_or (cout_d, g1,  g2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= 1'b0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_full_adder_1bit_reg.sv
// Directed bench for full_adder_1bit_reg: reset, exhaustive truth table, edge and hold behaviour.
module tb_full_adder_1bit_reg;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   chg;
    logic mon_en;

    full_adder_1bit_reg_if bus ();

    full_adder_1bit_reg dut (
        .cin  (bus.cin),
        .a    (bus.a),
        .b    (bus.b),
        .clk  (clk),
        .sum  (bus.sum),
        .cout (bus.cout),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(bus.sum or bus.cout) begin
        if (mon_en) chg = chg + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {6'b0, bus.cout, bus.sum};
    endfunction

    task automatic set_in(input logic c, input logic x, input logic y);
        bus.cin = c;
        bus.a   = x;
        bus.b   = y;
    endtask

    // Expected {cout,sum} indexed by {cin,a,b}, worked out by hand.
    logic [1:0] exp_tbl [8];

    initial begin
        total  = 0;
        bad    = 0;
        chg    = 0;
        mon_en = 1'b0;
        exp_tbl[0] = 2'b00; exp_tbl[1] = 2'b01; exp_tbl[2] = 2'b01; exp_tbl[3] = 2'b10;
        exp_tbl[4] = 2'b01; exp_tbl[5] = 2'b10; exp_tbl[6] = 2'b10; exp_tbl[7] = 2'b11;

        // Reset held with all inputs high
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b1);
        #1;
        chk("reset_async", outs(), 8'b00);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_hold", outs(), 8'b00);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_release_no_edge", outs(), 8'b00);
        @(posedge clk); #1;
        chk("first_capture", outs(), 8'b11);

        // Exhaustive truth table, one vector per rising edge
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vec;
            vec = v[2:0];
            @(negedge clk);
            set_in(vec[2], vec[1], vec[0]);
            @(posedge clk); #1;
            chk($sformatf("tt_%b", vec), outs(), {6'b0, exp_tbl[v]});
        end

        // Hold 1/1 across idle cycles, no output activity
        chg    = 0;
        mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("hold_neg", outs(), 8'b11);
            @(posedge clk); #1;
            chk("hold_pos", outs(), 8'b11);
        end
        mon_en = 1'b0;
        chk("hold_glitch", chg[7:0], 8'd0);

        // Falling edge must not capture
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("fe_setup", outs(), 8'b01);
        #1;
        bus.b = 1'b1;
        #1;
        chk("fe_mid_cycle", outs(), 8'b01);
        @(negedge clk); #1;
        chk("fe_immune", outs(), 8'b01);
        @(posedge clk); #1;
        chk("fe_next_rise", outs(), 8'b10);

        // Async reset pulse between edges
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst_clear", outs(), 8'b00);
        #1;
        rst = 1'b0;
        #1;
        chk("async_rst_no_edge", outs(), 8'b00);
        @(posedge clk); #1;
        chk("async_rst_restore", outs(), 8'b10);

        // All three inputs flip together before one edge
        @(negedge clk);
        set_in(1'b0, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("toggle_pre", outs(), 8'b10);
        @(negedge clk);
        set_in(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("toggle_post", outs(), 8'b01);

        // Reset asserted on a rising edge wins
        @(posedge clk);
        rst = 1'b1;
        #1;
        chk("rst_on_edge", outs(), 8'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_on_edge_recover", outs(), 8'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
